// File: rtl/alu_sequencer_pkg.sv
// Shared sequencing states, instruction field layout and ALU op codes for alu_sequencer.
package alu_sequencer_pkg;

  localparam int INSTR_W = 16;
  localparam int WAIT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_A    = 3'd1,
    ST_LAT_A   = 3'd2,
    ST_RD_B    = 3'd3,
    ST_LAT_B   = 3'd4,
    ST_EXEC    = 3'd5,
    ST_LAT_OUT = 3'd6,
    ST_WRITE   = 3'd7
  } state_t;

  // The ALU decodes these; the sequencer only passes the op field through.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MOV = 3'd7
  } alu_op_t;

  // imm6 overlays src_b and the low three bits.
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] src_a;
    logic       imm;
    logic [2:0] src_b;
    logic [2:0] imm_lo;
  } instr_t;

  function automatic logic [5:0] imm6(input instr_t i);
    return {i.src_b, i.imm_lo};
  endfunction

endpackage

// File: rtl/alu_sequencer_wait_counter.sv
// EXEC-phase wait counter: load a count, decrement to zero, expired_o high while zero.
// Synchronous active-high reset; one-cycle load-to-flag latency.
module seq_wait_counter
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              dec_i,
  input  logic [WAIT_W-1:0] load_val_i,
  output logic              expired_o
);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// One-instruction-at-a-time strobe sequencer for the ALU datapath; accept-to-done is 6+EXEC_WAIT cycles,
// instr_ready only in IDLE. Define SEQ_IMM_EN to let the imm flag source operand B from imm6.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3,
  parameter int EXEC_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic                 done,
  output logic [2:0]           opControl,
  output logic                 ALUin0,
  output logic                 ALUin1,
  output logic                 ALUOutLatch,
  output logic                 ALUOutEn,
  output logic [REG_IDX_W-1:0] rf_sel,
  output logic                 rf_out_en,
  output logic                 rf_in_en,
  output logic [DATA_W-1:0]    imm_out,
  output logic                 imm_out_en
);

  // EXEC lasts EXEC_WAIT cycles: the counter is loaded with one less and exits on zero.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = (EXEC_WAIT > 0) ? WAIT_W'(EXEC_WAIT - 1) : '0;

  state_t                 state_q, state_d;
  instr_t                 instr_q, instr_d;
  logic                   wait_expired;
  logic                   b_is_imm;
  logic [REG_IDX_W-1:0]   rf_sel_d;
  logic                   rf_out_en_d;
  logic                   b_imm_d;

  seq_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == ST_LAT_B),
    .dec_i      (state_q == ST_EXEC),
    .load_val_i (WAIT_LOAD),
    .expired_o  (wait_expired)
  );

`ifdef SEQ_IMM_EN
  assign b_is_imm = instr_d.imm;
`else
  assign b_is_imm = 1'b0;
  logic unused_fields;
  assign unused_fields = ^{instr_d.imm, instr_d.imm_lo, b_imm_d};
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d = ST_RD_A;
          instr_d = instr_t'(instr);
        end
      end
      ST_RD_A:    state_d = ST_LAT_A;
      ST_LAT_A:   state_d = ST_RD_B;
      ST_RD_B:    state_d = ST_LAT_B;
      ST_LAT_B:   state_d = (EXEC_WAIT > 0) ? ST_EXEC : ST_LAT_OUT;
      ST_EXEC:    if (wait_expired) state_d = ST_LAT_OUT;
      ST_LAT_OUT: state_d = ST_WRITE;
      ST_WRITE:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus-side outputs decoded from the next state so they register alongside it.
  always_comb begin
    rf_sel_d    = '0;
    rf_out_en_d = 1'b0;
    b_imm_d     = 1'b0;
    unique case (state_d)
      ST_RD_A, ST_LAT_A: begin
        rf_sel_d    = REG_IDX_W'(instr_d.src_a);
        rf_out_en_d = 1'b1;
      end
      ST_RD_B, ST_LAT_B: begin
        rf_sel_d    = REG_IDX_W'(instr_d.src_b);
        rf_out_en_d = !b_is_imm;
        b_imm_d     = b_is_imm;
      end
      ST_WRITE: rf_sel_d = REG_IDX_W'(instr_d.dst);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      opControl   <= '0;
      ALUin0      <= 1'b0;
      ALUin1      <= 1'b0;
      ALUOutLatch <= 1'b0;
      ALUOutEn    <= 1'b0;
      rf_sel      <= '0;
      rf_out_en   <= 1'b0;
      rf_in_en    <= 1'b0;
`ifdef SEQ_IMM_EN
      imm_out     <= '0;
      imm_out_en  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      instr_ready <= (state_d == ST_IDLE);
      done        <= (state_d == ST_WRITE);
      opControl   <= (state_d == ST_IDLE) ? 3'b000 : instr_d.op;
      ALUin0      <= (state_d == ST_LAT_A);
      ALUin1      <= (state_d == ST_LAT_B);
      ALUOutLatch <= (state_d == ST_LAT_OUT);
      ALUOutEn    <= (state_d == ST_WRITE);
      rf_sel      <= rf_sel_d;
      rf_out_en   <= rf_out_en_d;
      rf_in_en    <= (state_d == ST_WRITE);
`ifdef SEQ_IMM_EN
      imm_out     <= b_imm_d ? DATA_W'(imm6(instr_d)) : '0;
      imm_out_en  <= b_imm_d;
`endif
    end
  end

`ifndef SEQ_IMM_EN
  assign imm_out    = '0;
  assign imm_out_en = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer against a cycle-offset reference model of the strobe schedule.
module tb_alu_sequencer;

  localparam int EW = 1;
  localparam int WB = 6 + EW;   // cycle offset of the write-back/done cycle
`ifdef SEQ_IMM_EN
  localparam bit IMM_BUILD = 1'b1;
`else
  localparam bit IMM_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready, done, ALUin0, ALUin1, ALUOutLatch, ALUOutEn;
  logic [2:0]  opControl, rf_sel;
  logic        rf_out_en, rf_in_en, imm_out_en;
  logic [15:0] imm_out;

  int tests_run = 0;
  int tests_failed = 0;
  int excl_viol = 0;

  alu_sequencer #(.DATA_W(16), .REG_IDX_W(3), .EXEC_WAIT(EW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .opControl(opControl),
    .ALUin0(ALUin0), .ALUin1(ALUin1), .ALUOutLatch(ALUOutLatch), .ALUOutEn(ALUOutEn),
    .rf_sel(rf_sel), .rf_out_en(rf_out_en), .rf_in_en(rf_in_en),
    .imm_out(imm_out), .imm_out_en(imm_out_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        done;
    logic [2:0]  op;
    logic        in0;
    logic        in1;
    logic        olat;
    logic        oen;
    logic [2:0]  sel;
    logic        roe;
    logic        rie;
    logic        imme;
    logic [15:0] imm;
  } obs_t;

  function automatic obs_t sample();
    obs_t o;
    o.rdy = instr_ready;  o.done = done;     o.op = opControl;
    o.in0 = ALUin0;       o.in1 = ALUin1;    o.olat = ALUOutLatch;
    o.oen = ALUOutEn;     o.sel = rf_sel;    o.roe = rf_out_en;
    o.rie = rf_in_en;     o.imme = imm_out_en; o.imm = imm_out;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // Expected outputs k cycles after the accepting edge (k outside 1..WB means idle).
  function automatic obs_t model(input int k, input logic [15:0] ins);
    obs_t e = '0;
    bit use_imm;
    use_imm = IMM_BUILD && ins[6];
    if (k < 1 || k > WB) return idle_obs();
    e.op = ins[15:13];
    if (k <= 2) begin
      e.sel = ins[9:7]; e.roe = 1'b1; e.in0 = (k == 2);
    end else if (k <= 4) begin
      e.sel = ins[5:3]; e.roe = !use_imm; e.imme = use_imm;
      e.imm = use_imm ? {10'b0, ins[5:0]} : 16'h0000;
      e.in1 = (k == 4);
    end else if (k == WB - 1) begin
      e.olat = 1'b1;
    end else if (k == WB) begin
      e.oen = 1'b1; e.sel = ins[12:10]; e.rie = 1'b1; e.done = 1'b1;
    end
    return e;
  endfunction

  // rf_sel matters only while the register file drives or captures; opControl only while busy.
  function automatic obs_t care(input obs_t o, input obs_t e);
    obs_t r = o;
    if (!(e.roe || e.rie)) r.sel = '0;
    if (e.rdy) r.op = '0;
    return r;
  endfunction

  always @(negedge clk)
    if ((int'(rf_out_en) + int'(ALUOutEn) + int'(imm_out_en)) > 1) excl_viol++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic issue(input logic [15:0] ins);
    int n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (instr_ready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL issue_timeout ready=%b required=1", instr_ready);
    end
    instr = ins; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
  endtask

  task automatic test_reset();
    obs_t g, e;
    logic [15:0] ins;
    rst = 1'b1; instr_valid = 1'b1; instr = 16'($urandom);
    repeat (2) @(negedge clk);
    g = sample(); e = idle_obs(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL reset_state got=%h required=%h", g, e); end
    rst = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    g = sample(); tests_run++;
    if (g !== e) begin tests_failed++; $display("FAIL reset_release got=%h required=%h", g, e); end
    ins = 16'($urandom);
    issue(ins);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      g = sample(); e = model(k, ins); tests_run++;
      if (care(g, e) !== care(e, e)) begin
        tests_failed++; $display("FAIL reset_pre k=%0d got=%h required=%h", k, g, e);
      end
    end
    rst = 1'b1; instr_valid = 1'b1; instr = 16'($urandom);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      g = sample(); e = idle_obs(); tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL reset_mid c=%0d got=%h required=%h", c, g, e); end
    end
    rst = 1'b0; instr_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g = sample(); e = idle_obs(); tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL reset_after c=%0d got=%h required=%h", c, g, e); end
    end
  endtask

  task automatic test_reg_op();
    obs_t g, e;
    logic [15:0] ins = 16'b001_011_001_0_010_000;
    issue(ins);
    for (int k = 1; k <= WB + 1; k++) begin
      if (k > 1) @(negedge clk);
      g = sample(); e = model(k, ins); tests_run++;
      if (care(g, e) !== care(e, e)) begin
        tests_failed++; $display("FAIL reg_op k=%0d got=%h required=%h", k, g, e);
      end
    end
  endtask

  task automatic test_imm();
    obs_t g, e;
    logic [15:0] ins = {3'b101, 3'b110, 3'b011, 1'b1, 6'h2A};
    issue(ins);
    for (int k = 1; k <= WB + 1; k++) begin
      if (k > 1) @(negedge clk);
      g = sample(); e = model(k, ins); tests_run++;
      if (care(g, e) !== care(e, e)) begin
        tests_failed++; $display("FAIL imm k=%0d got=%h required=%h", k, g, e);
      end
      if (k == 3) begin
        tests_run++;
        if (imm_out !== (IMM_BUILD ? 16'h002A : 16'h0000)) begin
          tests_failed++; $display("FAIL imm_value got=%h required=%h", imm_out, IMM_BUILD ? 16'h002A : 16'h0000);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    obs_t g, e;
    logic [15:0] ins1, ins2;
    ins1 = 16'($urandom);
    ins2 = 16'($urandom);
    ins2[15:13] = ~ins1[15:13];
    issue(ins1);
    for (int k = 1; k <= WB + 2; k++) begin
      if (k > 1) @(negedge clk);
      g = sample(); e = model(k, ins1); tests_run++;
      if (care(g, e) !== care(e, e)) begin
        tests_failed++; $display("FAIL busy_ignore k=%0d got=%h required=%h", k, g, e);
      end
      if (k == 3) begin instr = ins2; instr_valid = 1'b1; end
      if (k == 5) instr_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    obs_t g, e;
    logic [15:0] ins1, ins2;
    int n = 0;
    ins1 = 16'($urandom);
    ins2 = 16'($urandom);
    while (instr_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    instr = ins1; instr_valid = 1'b1;
    @(negedge clk);
    instr = ins2;
    for (int k = 1; k <= 2 * (WB + 1); k++) begin
      if (k > 1) @(negedge clk);
      g = sample();
      e = (k <= WB + 1) ? model(k, ins1) : model(k - (WB + 1), ins2);
      tests_run++;
      if (care(g, e) !== care(e, e)) begin
        tests_failed++; $display("FAIL back_to_back k=%0d got=%h required=%h", k, g, e);
      end
      if (k == WB + 2) begin instr_valid = 1'b0; instr = 16'($urandom); end
    end
  endtask

  task automatic test_random();
    obs_t g, e;
    logic [15:0] ins;
    for (int t = 0; t < 25; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ins = 16'($urandom);
      issue(ins);
      for (int k = 1; k <= WB + 1; k++) begin
        if (k > 1) begin
          instr = 16'($urandom);
          @(negedge clk);
        end
        g = sample(); e = model(k, ins); tests_run++;
        if (care(g, e) !== care(e, e)) begin
          tests_failed++; $display("FAIL random t=%0d k=%0d got=%h required=%h", t, k, g, e);
        end
      end
    end
  endtask

  task automatic test_exclusivity();
    tests_run++;
    if (excl_viol !== 0) begin
      tests_failed++; $display("FAIL bus_exclusivity violations=%0d required=0", excl_viol);
    end
  endtask

  initial begin
    test_reset();
    test_reg_op();
    test_imm();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_exclusivity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
